// File: rtl/booth_seq_accumulator.sv
// ---------------------------------------------------------------------------
// booth_seq_accumulator
//
// Sequential radix-4 Booth multiplier controller. It drives an external
// combinational multi-select barrel shifter and accumulates the result.
// Each RUN cycle presents one Booth digit to the shifter. The shifted
// multiplicand comes back on N_in in the same cycle. It is then added to
// or subtracted from the product register. A run-time count of low-order
// digits (approx_in) may be skipped to trade accuracy for latency.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start_in   : request valid, accepted when start_in & ready_out
//   ready_out  : high only while idle
//   A_in       : signed multiplier (NA bits)
//   B_in       : signed multiplicand (NB bits)
//   approx_in  : number of low Booth digits to skip (saturates at NA/2)
//   B_out      : latched multiplicand, feeds shifter B input
//   S_out      : shifter select, one-hot or zero
//   N_in       : shifter output (NA+NB-1 bits), combinational return
//   P_out      : signed product (approximate when digits are skipped)
//   valid_out  : product valid, held until ready_in
//   ready_in   : downstream accept
// ---------------------------------------------------------------------------
module booth_seq_accumulator #(
  parameter int NA = 8,
  parameter int NB = 8,
  parameter int KW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  output logic                 ready_out,
  input  logic [NA-1:0]        A_in,
  input  logic [NB-1:0]        B_in,
  input  logic [KW-1:0]        approx_in,
  output logic [NB-1:0]        B_out,
  output logic [NA-1:0]        S_out,
  input  logic [NA+NB-2:0]     N_in,
  output logic signed [NA+NB-1:0] P_out,
  output logic                 valid_out,
  input  logic                 ready_in
);

  localparam int ND = NA / 2;
  localparam int CW = $clog2(ND + 1);
  localparam int PW = NA + NB;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Booth triplet (A[2i+1], A[2i], A[2i-1]) with an implicit zero below bit 0.
  function automatic logic [2:0] booth_bits(input logic [NA-1:0] a,
                                            input logic [CW-1:0] idx);
    logic [NA:0] ax;
    ax = {a, 1'b0};
    booth_bits = 3'b000;
    for (int i = 0; i < ND; i++) begin
      if (idx == CW'(i)) booth_bits = ax[2*i +: 3];
    end
  endfunction

  // Shifter select: |d|=1 picks bit 2i, |d|=2 picks bit 2i+1, d=0 selects nothing.
  function automatic logic [NA-1:0] booth_sel(input logic [2:0] bits,
                                              input logic [CW-1:0] idx);
    logic mag1;
    logic mag2;
    mag1 = (bits == 3'b001) || (bits == 3'b010) ||
           (bits == 3'b101) || (bits == 3'b110);
    mag2 = (bits == 3'b011) || (bits == 3'b100);
    booth_sel = '0;
    for (int i = 0; i < ND; i++) begin
      if (idx == CW'(i)) begin
        booth_sel[2*i]   = mag1;
        booth_sel[2*i+1] = mag2;
      end
    end
  endfunction

  // Negative digits have the top bit set, except 111 which is zero.
  function automatic logic booth_neg(input logic [2:0] bits);
    booth_neg = bits[2] & ~(&bits);
  endfunction

  state_t                state_q, state_d;
  logic [NA-1:0]         a_q, a_d;
  logic [NB-1:0]         b_q, b_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [PW-1:0]  acc_q, acc_d;
  logic [NA-1:0]         s_q, s_d;
  logic                  neg_q, neg_d;
  logic                  ready_q, valid_q;
  logic [CW-1:0]         k_w;
  logic [2:0]            bits_d;
  logic signed [PW-1:0]  n_ext;

  // Skip count saturates at the digit count, which yields an all-zero product.
  always_comb begin
    if (32'(approx_in) >= 32'(ND)) k_w = CW'(ND);
    else                           k_w = CW'(approx_in);
  end

  assign n_ext = $signed({N_in[PW-2], N_in});

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          a_d     = A_in;
          b_d     = B_in;
          cnt_d   = k_w;
          acc_d   = '0;
          state_d = (k_w == CW'(ND)) ? DONE : RUN;
        end
      end
      RUN: begin
        // s_q is nonzero exactly when the current digit is nonzero.
        if (s_q != '0) acc_d = neg_q ? (acc_q - n_ext) : (acc_q + n_ext);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ND - 1)) state_d = DONE;
      end
      DONE: begin
        if (ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Select and sign for the digit that will be active next cycle are
    // precomputed so that S_out comes straight from a flop.
    bits_d = booth_bits(a_d, cnt_d);
    s_d    = (state_d == RUN) ? booth_sel(bits_d, cnt_d) : '0;
    neg_d  = (state_d == RUN) & booth_neg(bits_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      neg_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      neg_q   <= neg_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign S_out     = s_q;
  assign B_out     = b_q;
  assign P_out     = acc_q;

endmodule

// File: tb/tb_booth_seq_accumulator.sv
module tb_booth_seq_accumulator;

  localparam int NA = 8;
  localparam int NB = 8;
  localparam int KW = 3;
  localparam int ND = NA / 2;
  localparam int PW = NA + NB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_in = 1'b0;
  logic              ready_out;
  logic [NA-1:0]     A_in = '0;
  logic [NB-1:0]     B_in = '0;
  logic [KW-1:0]     approx_in = '0;
  logic [NB-1:0]     B_out;
  logic [NA-1:0]     S_out;
  logic [PW-2:0]     N_in;
  logic signed [PW-1:0] P_out;
  logic              valid_out;
  logic              ready_in = 1'b0;

  int errors = 0;
  int checks = 0;

  booth_seq_accumulator #(.NA(NA), .NB(NB), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .ready_out(ready_out),
    .A_in(A_in), .B_in(B_in), .approx_in(approx_in), .B_out(B_out),
    .S_out(S_out), .N_in(N_in), .P_out(P_out), .valid_out(valid_out),
    .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  // Barrel shifter model: sign-extended B shifted by each selected position.
  always_comb begin
    logic [PW-2:0] bx;
    bx = {{(NA-1){B_out[NB-1]}}, B_out};
    N_in = '0;
    for (int j = 0; j < NA; j++) begin
      if (S_out[j]) N_in = N_in | (bx << j);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Booth digit i of a from the arithmetic rule, A[-1]=0.
  function automatic int digit(input int a, input int i);
    logic [NA-1:0] av;
    int lo;
    av = NA'(a);
    lo = (i == 0) ? 0 : int'(av[2*i-1]);
    return -2 * int'(av[2*i+1]) + int'(av[2*i]) + lo;
  endfunction

  function automatic longint model_p(input int a, input int b, input int ax);
    int kk;
    longint sum;
    kk = (ax > ND) ? ND : ax;
    sum = 0;
    for (int i = kk; i < ND; i++)
      sum += longint'(digit(a, i)) * longint'(b) * (longint'(1) << (2 * i));
    return sum;
  endfunction

  function automatic logic [NA-1:0] exp_sel(input int a, input int i);
    int d;
    logic [NA-1:0] one;
    one = 1;
    if (i >= ND) return '0;
    d = digit(a, i);
    if (d == 0) return '0;
    if (d == 1 || d == -1) return one << (2 * i);
    return one << (2 * i + 1);
  endfunction

  // Runs one operation and checks select sequence, latency, product,
  // backpressure hold and return to idle.
  task automatic do_op(input int a, input int b, input int ax, input int hold,
                       input bit use_lit, input int lit_p, input string name);
    int kk;
    int cyc;
    logic signed [PW-1:0] expp;
    logic signed [PW-1:0] p_first;
    kk   = (ax > ND) ? ND : ax;
    expp = PW'(model_p(a, b, ax));
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", name, ready_out);
    end
    A_in = NA'(a); B_in = NB'(b); approx_in = KW'(ax); start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    A_in = NA'($urandom); B_in = NB'($urandom); approx_in = KW'($urandom);
    cyc = 0;
    while (valid_out !== 1'b1 && cyc < 12) begin
      checks++;
      if (S_out !== exp_sel(a, kk + cyc)) begin
        errors++;
        $display("FAIL %s S_run%0d: got %h want %h", name, cyc, S_out, exp_sel(a, kk + cyc));
      end
      if (cyc == 0) begin
        checks++;
        if (B_out !== NB'(b) || ready_out !== 1'b0) begin
          errors++;
          $display("FAIL %s busy: got B_out=%h ready=%b want B_out=%h ready=0",
                   name, B_out, ready_out, NB'(b));
        end
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != ND - kk) begin
      errors++; $display("FAIL %s run_cycles: got %0d want %0d", name, cyc, ND - kk);
    end
    checks++;
    if (P_out !== expp || S_out !== '0 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL %s product: got P=%h S=%h ready=%b want P=%h S=00 ready=0",
               name, P_out, S_out, ready_out, expp);
    end
    if (use_lit) begin
      checks++;
      if (P_out !== PW'(lit_p)) begin
        errors++; $display("FAIL %s literal_p: got %h want %h", name, P_out, PW'(lit_p));
      end
    end
    if (kk == 0) begin
      checks++;
      if (P_out !== PW'(a * b)) begin
        errors++; $display("FAIL %s exact_p: got %h want %h", name, P_out, PW'(a * b));
      end
    end
    p_first = P_out;
    for (int h = 0; h < hold; h++) begin
      ready_in = 1'b0;
      start_in = 1'b1;
      A_in = NA'($urandom); B_in = NB'($urandom);
      @(negedge clk);
      start_in = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || P_out !== p_first || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got v=%b P=%h ready=%b want v=1 P=%h ready=0",
                 name, h, valid_out, P_out, ready_out, p_first);
      end
    end
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got v=%b ready=%b want v=0 ready=1", name, valid_out, ready_out);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || P_out !== '0 ||
        S_out !== '0 || B_out !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b P=%h S=%h B=%h want 1 0 0 0 0",
               ready_out, valid_out, P_out, S_out, B_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b want 1 0", ready_out, valid_out);
    end
  endtask

  task automatic test_directed();
    do_op(7, 3, 0, 0, 1'b1, 21, "a7b3k0");
    do_op(-128, -128, 0, 0, 1'b1, 16384, "min_min");
    do_op(7, 3, 1, 0, 1'b1, 24, "a7b3k1");
    do_op(-57, 99, 5, 0, 1'b1, 0, "sat_k");
    do_op(127, -128, 0, 0, 1'b1, -16256, "max_min");
  endtask

  task automatic test_backpressure();
    do_op(-3, 5, 0, 3, 1'b1, -15, "backpressure");
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    A_in = 8'd7; B_in = 8'd3; approx_in = '0; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    checks++;
    if (S_out !== 8'h08) begin
      errors++; $display("FAIL midrun_S: got %h want 08", S_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || P_out !== '0 ||
        S_out !== '0 || B_out !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%b v=%b P=%h S=%h B=%h want 1 0 0 0 0",
               ready_out, valid_out, P_out, S_out, B_out);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(2, 2, 0, 0, 1'b1, 4, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    int a;
    int b;
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      a = $signed(ra);
      b = $signed(rb);
      do_op(a, b, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
            1'b0, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
